// File: rtl/dmem_if.sv
// Core data-port bus plus the TX byte stream of the data memory responder.
// master = core/downstream side, slave = dmem_responder.
interface dmem_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic            we;
  logic [XLEN-1:0] rdata;
  logic            tx_valid;
  logic [7:0]      tx_data;
  logic            tx_ready;

  modport master (
    output addr, wdata, we, tx_ready,
    input  rdata, tx_valid, tx_data
  );

  modport slave (
    input  addr, wdata, we, tx_ready,
    output rdata, tx_valid, tx_data
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-side memory responder: word RAM plus MMIO window (TX FIFO, STATUS, CYCCNT).
// Optional cycle counter is built only when DMEM_CYCCNT_EN is defined.
module dmem_responder #(
  parameter int XLEN       = 32,
  parameter int RAM_AW     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic   clk,
  input  logic   reset,
  dmem_if.slave  bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0]   mem [2**RAM_AW];
  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic              overflow;

  logic              is_mmio;
  logic [RAM_AW-1:0] ram_idx;
  logic [1:0]        off;
  logic              empty;
  logic              full;
  logic              push_req;
  logic              push;
  logic              pop;
  logic              ovf_set;
  logic              ovf_clr;
  logic              ram_we;
  logic [XLEN-1:0]   status;
  logic [XLEN-1:0]   cyc_rd;
  logic              unused_addr_bits;

  assign is_mmio = bus.addr[XLEN-1];
  assign ram_idx = bus.addr[RAM_AW+1:2];
  assign off     = bus.addr[3:2];
  assign unused_addr_bits = ^{bus.addr[XLEN-2:RAM_AW+2], bus.addr[1:0]};

  assign empty = (count == '0);
  assign full  = (count == CW'(FIFO_DEPTH));

  // TX stream: tx_data is meaningful while tx_valid is high; a byte transfers
  // at the rising edge where tx_valid && tx_ready, and tx_valid never waits on tx_ready.
  assign bus.tx_valid = !empty;
  assign bus.tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr];

  assign pop      = !empty && bus.tx_ready;
  assign push_req = bus.we && is_mmio && (off == 2'd0);
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign ovf_clr  = bus.we && is_mmio && (off == 2'd1) && bus.wdata[2];
  assign ram_we   = bus.we && !is_mmio;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // Storage arrays carry no reset; emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_idx] <= bus.wdata;
  end

`ifdef DMEM_CYCCNT_EN
  logic [XLEN-1:0] cyccnt;
  logic            cyc_wr;

  assign cyc_wr = bus.we && is_mmio && (off == 2'd2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       cyccnt <= '0;
    else if (cyc_wr) cyccnt <= bus.wdata;
    else             cyccnt <= cyccnt + XLEN'(1);
  end

  assign cyc_rd = cyccnt;
`else
  assign cyc_rd = '0;
`endif

  always_comb begin
    status        = '0;
    status[2:0]   = {overflow, full, empty};
    status[3+:CW] = count;
  end

  always_comb begin
    bus.rdata = '0;
    if (!is_mmio) begin
      bus.rdata = mem[ram_idx];
    end else begin
      case (off)
        2'd1:    bus.rdata = status;
        2'd2:    bus.rdata = cyc_rd;
        default: bus.rdata = '0;
      endcase
    end
  end
endmodule
